mem_initiator: RTL
==================

# mem_initiator

Bus-master front end for the 256 x 16-bit unified memory. Accepts single read, single write, block fill and block copy commands from the control unit over a valid/ready handshake and drives the memory's enable/writeEnable/address/writeData port, capturing its asynchronous readData. It is the initiator side of the memory interface; every memory access in the processor goes through it.

## Interface
Parameters
- ADDR_W, 8, memory address width; address space 0..255
- DATA_W, 16, memory word width

Ports
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- reqValid  in  1  command present
- reqReady  out  1  block idle and able to accept
- reqOp  in  2  command: 00 READ, 01 WRITE, 10 FILL, 11 COPY
- reqAddr  in  ADDR_W  READ/WRITE/FILL address; COPY source
- reqDstAddr  in  ADDR_W  COPY destination; ignored otherwise
- reqLen  in  ADDR_W  FILL/COPY word count; 0 = no access; ignored for READ/WRITE
- reqData  in  DATA_W  WRITE/FILL data
- rspValid  out  1  one-cycle completion pulse
- rspData  out  DATA_W  READ result; holds until next READ completes
- busy  out  1  command in progress (inverse of reqReady)
- memEnable  out  1  to memory enable
- memWriteEnable  out  1  to memory writeEnable
- memAddress  out  ADDR_W  to memory address
- memWriteData  out  DATA_W  to memory writeData
- memReadData  in  DATA_W  from memory readData (combinational, 0 when disabled)

## Operation
- States: IDLE, RD, WR, CP_RD, CP_WR, RESP.
- IDLE: reqReady=1; memEnable=0, memWriteEnable=0. On reqValid: latch op, addresses, len, data; next state by op.
- READ: IDLE -> RD -> RESP. RD drives memEnable=1, memWriteEnable=0, memAddress=addr; memReadData captured into rspData on the posedge leaving RD.
- WRITE: IDLE -> WR (one cycle, memEnable=memWriteEnable=1, address/data latched) -> RESP.
- FILL: IDLE -> WR repeated reqLen cycles; address +1 each cycle, mod 256 (255 wraps to 0); same data each word -> RESP.
- COPY: per word CP_RD (read src, capture memReadData into internal hold register) then CP_WR (write hold to dst); src and dst each +1 mod 256 after CP_WR; reqLen iterations -> RESP. Strictly ascending forward copy; overlapping regions with dst > src propagate already-copied data — defined behaviour, not corrected.
- reqLen=0 for FILL/COPY: IDLE -> RESP directly, no memory access.
- RESP: rspValid=1 for exactly one cycle, then IDLE. Illegal combinations do not exist (all 4 ops defined).
- Remaining-count register decremented once per word written; terminal when it reaches 1 at the write cycle.

## Timing
- Reset (async, any state): state IDLE; reqReady=1, busy=0, rspValid=0, rspData=0, memEnable=0, memWriteEnable=0, memAddress=0, memWriteData=0. Words already written by an interrupted FILL/COPY stay in memory.
- Memory-side outputs are registered (updated on the edge entering the state); no combinational path from req* to mem*.
- Accept at edge 0: READ/WRITE rspValid high in cycle 2 (edge 0 -> RD/WR, edge 1 -> RESP). FILL of N: rspValid in cycle N+1. COPY of N: cycle 2N+1. Len 0: cycle 1.
- reqValid while busy is ignored; requester must hold request until reqReady sampled high. reqValid in the RESP cycle is not accepted; earliest next accept is the cycle after RESP (back-to-back throughput: one command per latency+1 cycles).
- Memory write commits at the posedge ending a WR/CP_WR cycle; a CP_RD directly after a CP_WR to the same address sees the new value.

## Structure
- Shared package mem_pkg: ADDR_W, DATA_W, op encodings (OP_READ, OP_WRITE, OP_FILL, OP_COPY), state enum.
- Single module; counters and address incrementers inline. No sub-module required.

## Test plan
- Reset mid-COPY (len 10, after 3 words) -> all outputs at reset values next cycle; dst+0..dst+2 copied, dst+3.. unchanged; reqReady=1.
- WRITE addr 0x10 data 0xBEEF, then READ 0x10 -> rspValid cycle 2 of each; rspData=0xBEEF.
- FILL addr 0xFE len 4 data 0x1234 -> words 0xFE,0xFF,0x00,0x01 = 0x1234; 0x02 untouched; rspValid in cycle 5.
- COPY src 0x20 dst 0x40 len 3 with mem[0x20..0x22]=0xA,0xB,0xC -> mem[0x40..0x42]=0xA,0xB,0xC; rspValid in cycle 7; memEnable alternates we=0/1.
- FILL len 0 and COPY len 0 -> rspValid in cycle 1, memEnable never asserted.
- reqValid held high during busy with different command -> only first command executes; second accepted cycle after rspValid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory initiator.
//   ADDR_W / DATA_W : memory address and word widths (256 x 16-bit memory)
//   OP_*            : request opcode encodings on reqOp
//   state_e         : initiator FSM states
package mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StCpRd,
    StCpWr,
    StResp
  } state_e;

endpackage

// File: rtl/mem_initiator.sv
// Bus-master front end for the unified memory. Accepts READ / WRITE / FILL / COPY commands over
// a valid/ready handshake and sequences the memory port, one word access per cycle.
//   clock, reset          : clock, asynchronous active-high reset
//   reqValid/reqReady     : command handshake (reqReady high only in idle)
//   reqOp/reqAddr/reqDstAddr/reqLen/reqData : command fields, latched on accept
//   rspValid/rspData      : one-cycle completion pulse; rspData holds the last READ result
//   busy                  : command in progress
//   memEnable/memWriteEnable/memAddress/memWriteData : registered memory drive
//   memReadData           : combinational read data from memory
module mem_initiator #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [1:0]        reqOp,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [ADDR_W-1:0] reqDstAddr,
  input  logic [ADDR_W-1:0] reqLen,
  input  logic [DATA_W-1:0] reqData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              busy,
  output logic              memEnable,
  output logic              memWriteEnable,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData
);

  import mem_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  // Also serves as the COPY hold register: the word read in CpRd is written from here in CpWr.
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Memory-side signals are computed for the state being entered and registered, so the
  // memory port never sees a combinational path from the request inputs.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    rsp_data_d  = rsp_data_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (reqValid) begin
          src_d       = reqAddr;
          dst_d       = reqDstAddr;
          len_d       = reqLen;
          mem_addr_d  = reqAddr;
          mem_wdata_d = reqData;
          unique case (reqOp)
            OP_READ: begin
              state_d  = StRd;
              mem_en_d = 1'b1;
            end
            OP_WRITE: begin
              // A single write is a one-word fill.
              len_d    = ADDR_W'(1);
              state_d  = StWr;
              mem_en_d = 1'b1;
              mem_we_d = 1'b1;
            end
            OP_FILL: begin
              if (reqLen == '0) begin
                state_d = StResp;
              end else begin
                state_d  = StWr;
                mem_en_d = 1'b1;
                mem_we_d = 1'b1;
              end
            end
            OP_COPY: begin
              if (reqLen == '0) begin
                state_d = StResp;
              end else begin
                state_d  = StCpRd;
                mem_en_d = 1'b1;
              end
            end
            default: state_d = StIdle;
          endcase
        end
      end

      StRd: begin
        rsp_data_d = memReadData;
        state_d    = StResp;
      end

      StWr: begin
        if (len_q == ADDR_W'(1)) begin
          state_d = StResp;
        end else begin
          len_d      = len_q - ADDR_W'(1);
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b1;
        end
      end

      StCpRd: begin
        mem_wdata_d = memReadData;
        mem_addr_d  = dst_q;
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        state_d     = StCpWr;
      end

      StCpWr: begin
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        if (len_q == ADDR_W'(1)) begin
          state_d = StResp;
        end else begin
          len_d      = len_q - ADDR_W'(1);
          mem_addr_d = src_q + ADDR_W'(1);
          mem_en_d   = 1'b1;
          state_d    = StCpRd;
        end
      end

      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      rsp_data_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      rsp_data_q  <= rsp_data_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign reqReady       = (state_q == StIdle);
  assign busy           = ~reqReady;
  assign rspValid       = (state_q == StResp);
  assign rspData        = rsp_data_q;
  assign memEnable      = mem_en_q;
  assign memWriteEnable = mem_we_q;
  assign memAddress     = mem_addr_q;
  assign memWriteData   = mem_wdata_q;

endmodule
